// File: rtl/riscv_mem_arbiter.sv
// Shares one variable-latency memory bus between the RV32I fetch and load/store ports.
// Data wins arbitration unless fetch has been passed over STARVE_MAX times; a watchdog aborts hung accesses.
module riscv_mem_arbiter #(
    parameter int TIMEOUT    = 255,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ack,
    output logic        i_err,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic [3:0]  d_we,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        d_err,
    output logic        m_req,
    output logic [31:0] m_addr,
    output logic [3:0]  m_we,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_ready,
    output logic        grant_d
);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    localparam logic [15:0] LP_TO_LAST   = 16'(TIMEOUT - 1);
    localparam logic [7:0]  LP_STARVE_MX = 8'(STARVE_MAX);

    state_t      r_state, w_state;
    logic [15:0] r_toCnt, w_toCnt;
    logic [7:0]  r_starveCnt, w_starveCnt;
    logic [31:0] r_iRdata, w_iRdata;
    logic [31:0] r_dRdata, w_dRdata;
    logic        r_iAck, w_iAck, r_iErr, w_iErr;
    logic        r_dAck, w_dAck, r_dErr, w_dErr;
    logic        r_mReq, w_mReq;
    logic [31:0] r_mAddr, w_mAddr;
    logic [3:0]  r_mWe, w_mWe;
    logic [31:0] r_mWdata, w_mWdata;
    logic        r_grantD, w_grantD;

    // A port in its ack cycle is not eligible, which stops a held request being granted twice.
    logic w_iElig, w_dElig, w_pickI;
    assign w_iElig = i_req & ~r_iAck;
    assign w_dElig = d_req & ~r_dAck;
    assign w_pickI = w_iElig & (~w_dElig | (r_starveCnt == LP_STARVE_MX));

    always_comb begin
        w_state     = r_state;
        w_toCnt     = r_toCnt;
        w_starveCnt = r_starveCnt;
        w_iRdata    = r_iRdata;
        w_dRdata    = r_dRdata;
        w_iAck      = 1'b0;
        w_iErr      = 1'b0;
        w_dAck      = 1'b0;
        w_dErr      = 1'b0;
        w_mReq      = r_mReq;
        w_mAddr     = r_mAddr;
        w_mWe       = r_mWe;
        w_mWdata    = r_mWdata;
        w_grantD    = r_grantD;

        unique case (r_state)
            IDLE: begin
                if (w_pickI) begin
                    w_mAddr     = i_addr;
                    w_mWe       = 4'b0000;
                    w_mWdata    = 32'h0;
                    w_mReq      = 1'b1;
                    w_grantD    = 1'b0;
                    w_toCnt     = 16'h0;
                    w_starveCnt = 8'h0;
                    w_state     = BUSY_I;
                end else if (w_dElig) begin
                    w_mAddr  = d_addr;
                    w_mWe    = d_we;
                    w_mWdata = d_wdata;
                    w_mReq   = 1'b1;
                    w_grantD = 1'b1;
                    w_toCnt  = 16'h0;
                    w_state  = BUSY_D;
                    if (!i_req) begin
                        w_starveCnt = 8'h0;
                    end else if (r_starveCnt != LP_STARVE_MX) begin
                        w_starveCnt = r_starveCnt + 8'h1;
                    end
                end
            end
            BUSY_I, BUSY_D: begin
                if (m_ready || (r_toCnt == LP_TO_LAST)) begin
                    w_mReq  = 1'b0;
                    w_toCnt = 16'h0;
                    w_state = IDLE;
                    if (r_state == BUSY_D) begin
                        w_dAck = 1'b1;
                        w_dErr = ~m_ready;
                        if (!m_ready) begin
                            w_dRdata = 32'h0;
                        end else if (r_mWe == 4'b0000) begin
                            w_dRdata = m_rdata;
                        end
                    end else begin
                        w_iAck = 1'b1;
                        w_iErr = ~m_ready;
                        w_iRdata = m_ready ? m_rdata : 32'h0;
                    end
                end else begin
                    w_toCnt = r_toCnt + 16'h1;
                end
            end
            default: begin
                w_state = IDLE;
            end
        endcase
    end

    // Every output is a register, so reset clears the bus request without waiting for an edge.
    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            r_state     <= IDLE;
            r_toCnt     <= 16'h0;
            r_starveCnt <= 8'h0;
            r_iRdata    <= 32'h0;
            r_dRdata    <= 32'h0;
            r_iAck      <= 1'b0;
            r_iErr      <= 1'b0;
            r_dAck      <= 1'b0;
            r_dErr      <= 1'b0;
            r_mReq      <= 1'b0;
            r_mAddr     <= 32'h0;
            r_mWe       <= 4'b0000;
            r_mWdata    <= 32'h0;
            r_grantD    <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_toCnt     <= w_toCnt;
            r_starveCnt <= w_starveCnt;
            r_iRdata    <= w_iRdata;
            r_dRdata    <= w_dRdata;
            r_iAck      <= w_iAck;
            r_iErr      <= w_iErr;
            r_dAck      <= w_dAck;
            r_dErr      <= w_dErr;
            r_mReq      <= w_mReq;
            r_mAddr     <= w_mAddr;
            r_mWe       <= w_mWe;
            r_mWdata    <= w_mWdata;
            r_grantD    <= w_grantD;
        end
    end

    assign i_rdata = r_iRdata;
    assign i_ack   = r_iAck;
    assign i_err   = r_iErr;
    assign d_rdata = r_dRdata;
    assign d_ack   = r_dAck;
    assign d_err   = r_dErr;
    assign m_req   = r_mReq;
    assign m_addr  = r_mAddr;
    assign m_we    = r_mWe;
    assign m_wdata = r_mWdata;
    assign grant_d = r_grantD;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Scoreboard bench for riscv_mem_arbiter: stimulus queues expected acks, a monitor checks each ack as it appears.
// A behavioural memory answers m_req after a programmable latency, or never when hung.
module tb_riscv_mem_arbiter;

    localparam int TB_TIMEOUT = 8;
    localparam int TB_STARVE  = 4;

    logic        clk = 1'b0;
    logic        clrn;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ack, i_err;
    logic        d_req;
    logic [31:0] d_addr;
    logic [3:0]  d_we;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack, d_err;
    logic        m_req;
    logic [31:0] m_addr;
    logic [3:0]  m_we;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_ready;
    logic        grant_d;

    riscv_mem_arbiter #(.TIMEOUT(TB_TIMEOUT), .STARVE_MAX(TB_STARVE)) dut (
        .clk(clk), .clrn(clrn),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack), .i_err(i_err),
        .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
        .m_req(m_req), .m_addr(m_addr), .m_we(m_we), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ready(m_ready), .grant_d(grant_d)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        bit          isData;
        logic [31:0] rdata;
        bit          err;
        int          cycle;
    } expAck_t;

    expAck_t     expQ[$];
    int          checkCnt = 0;
    int          failCnt  = 0;
    int          cycleCnt = 0;
    int          memLat   = 1;
    bit          memHang  = 1'b0;
    bit          strayReady = 1'b0;
    int          busyCnt  = 0;
    logic [31:0] memArr [logic [31:0]];

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCnt++;
        if (act !== exp) begin
            failCnt++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cycleCnt);
        end
    endtask

    function automatic logic [31:0] memRead(input logic [31:0] a);
        return memArr.exists(a) ? memArr[a] : 32'h0;
    endfunction

    // Memory model: raises m_ready in the memLat-th busy cycle; write completions return junk on m_rdata.
    always @(negedge clk) begin
        if (clrn) begin
            m_ready = 1'b0;
            busyCnt = 0;
        end else if (strayReady) begin
            m_ready = 1'b1;
            m_rdata = 32'hBAD0BAD0;
        end else if (m_req && !memHang) begin
            busyCnt++;
            if (busyCnt == memLat) begin
                m_ready = 1'b1;
                if (m_we == 4'b0000) begin
                    m_rdata = memRead(m_addr);
                end else begin
                    logic [31:0] tmp;
                    tmp = memRead(m_addr);
                    for (int b = 0; b < 4; b++)
                        if (m_we[b]) tmp[8*b +: 8] = m_wdata[8*b +: 8];
                    memArr[m_addr] = tmp;
                    m_rdata = 32'hDEADBEEF;
                end
            end else begin
                m_ready = 1'b0;
            end
        end else begin
            m_ready = 1'b0;
            busyCnt = 0;
        end
    end

    // Monitor: every ack must match the head of the expectation queue in port, cycle, data and error.
    always @(posedge clk) begin
        #1;
        if (i_ack || d_ack) begin
            checkOutput("dualAck", 32'(i_ack & d_ack), 32'd0);
            if (expQ.size() == 0) begin
                checkCnt++;
                failCnt++;
                $display("[TB] FAIL unexpectedAck: got i_ack=%0b d_ack=%0b, expected no ack (cycle %0d)",
                         i_ack, d_ack, cycleCnt);
            end else begin
                expAck_t e;
                e = expQ.pop_front();
                checkOutput("ackPort", 32'(d_ack), 32'(e.isData));
                checkOutput("ackCycle", 32'(cycleCnt), 32'(e.cycle));
                checkOutput("ackRdata", e.isData ? d_rdata : i_rdata, e.rdata);
                checkOutput("ackErr", 32'(e.isData ? d_err : i_err), 32'(e.err));
                checkOutput("otherErr", 32'(e.isData ? i_err : d_err), 32'd0);
            end
        end
    end

    task automatic pushExp(input bit isData, input logic [31:0] rdata, input bit err, input int cyc);
        expAck_t e;
        e.isData = isData;
        e.rdata  = rdata;
        e.err    = err;
        e.cycle  = cyc;
        expQ.push_back(e);
    endtask

    // One complete access on one port; the request is dropped in the ack cycle.
    task automatic applyStimulus(input bit isData, input logic [31:0] addr, input logic [3:0] we,
                                 input logic [31:0] wdata, input int lat, input bit hang,
                                 input logic [31:0] expRdata, input bit expErr);
        bit seen;
        @(negedge clk);
        memLat  = lat;
        memHang = hang;
        if (isData) begin
            d_req = 1'b1; d_addr = addr; d_we = we; d_wdata = wdata;
        end else begin
            i_req = 1'b1; i_addr = addr;
        end
        pushExp(isData, expRdata, expErr, cycleCnt + 1 + (hang ? TB_TIMEOUT : lat));
        @(negedge clk);
        checkOutput("mReqBusy", 32'(m_req), 32'd1);
        checkOutput("mAddr", m_addr, addr);
        checkOutput("mWe", 32'(m_we), isData ? 32'(we) : 32'd0);
        checkOutput("grantD", 32'(grant_d), 32'(isData));
        seen = (isData ? d_ack : i_ack);
        for (int n = 0; n < 300 && !seen; n++) begin
            @(negedge clk);
            seen = (isData ? d_ack : i_ack);
        end
        if (!seen) begin
            checkCnt++;
            failCnt++;
            $display("[TB] FAIL ackWait: got no ack within 300 cycles, expected an ack");
        end
        checkOutput("mReqAfterAck", 32'(m_req), 32'd0);
        if (isData) d_req = 1'b0; else i_req = 1'b0;
        memHang = 1'b0;
    endtask

    initial begin
        int c;
        clrn = 1'b1;
        i_req = 1'b0; i_addr = 32'h0;
        d_req = 1'b0; d_addr = 32'h0; d_we = 4'b0000; d_wdata = 32'h0;
        m_rdata = 32'h0; m_ready = 1'b0;
        memArr[32'h100]  = 32'h00500093;
        memArr[32'h104]  = 32'h00000013;
        memArr[32'h3000] = 32'hCAFE0001;
        repeat (3) @(negedge clk);
        checkOutput("rstMReq", 32'(m_req), 32'd0);
        checkOutput("rstGrantD", 32'(grant_d), 32'd0);
        checkOutput("rstAcks", {28'd0, i_ack, i_err, d_ack, d_err}, 32'd0);
        checkOutput("rstIRdata", i_rdata, 32'h0);
        checkOutput("rstDRdata", d_rdata, 32'h0);
        checkOutput("rstMBus", m_addr | m_wdata | 32'(m_we), 32'h0);
        clrn = 1'b0;
        @(negedge clk);

        $display("[TB] single fetch");
        applyStimulus(1'b0, 32'h100, 4'b0000, 32'h0, 1, 1'b0, 32'h00500093, 1'b0);

        $display("[TB] store then load");
        applyStimulus(1'b1, 32'h2000, 4'b0011, 32'h00001234, 1, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b1, 32'h2000, 4'b0000, 32'h0, 3, 1'b0, 32'h00001234, 1'b0);

        $display("[TB] stray m_ready while idle");
        @(negedge clk);
        strayReady = 1'b1;
        @(negedge clk);
        @(negedge clk);
        strayReady = 1'b0;
        checkOutput("strayAck", 32'({i_ack, d_ack}), 32'd0);
        checkOutput("strayMReq", 32'(m_req), 32'd0);

        $display("[TB] simultaneous requests");
        @(negedge clk);
        memLat = 1;
        c = cycleCnt;
        i_req = 1'b1; i_addr = 32'h104;
        d_req = 1'b1; d_addr = 32'h2000; d_we = 4'b0000;
        pushExp(1'b1, 32'h00001234, 1'b0, c + 2);
        pushExp(1'b0, 32'h00000013, 1'b0, c + 4);
        @(negedge clk);
        checkOutput("simulGrant", 32'(grant_d), 32'd1);
        @(negedge clk);
        d_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        i_req = 1'b0;
        repeat (2) @(negedge clk);

        // The fetch requester withdraws during each data ack so fetch only competes when data is also eligible.
        $display("[TB] starvation guard");
        @(negedge clk);
        memLat = 1;
        c = cycleCnt;
        d_req = 1'b1; d_addr = 32'h3000; d_we = 4'b0000;
        i_addr = 32'h100;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            i_req = 1'b1;
            pushExp(1'b1, 32'hCAFE0001, 1'b0, c + 2 + 3 * k);
            @(negedge clk);
            checkOutput("starveDataGrant", 32'(grant_d), 32'd1);
            @(negedge clk);
            i_req = 1'b0;
        end
        @(negedge clk);
        i_req = 1'b1;
        pushExp(1'b0, 32'h00500093, 1'b0, c + 14);
        pushExp(1'b1, 32'hCAFE0001, 1'b0, c + 16);
        @(negedge clk);
        checkOutput("starveFetchGrant", 32'(grant_d), 32'd0);
        @(negedge clk);
        i_req = 1'b0;
        @(negedge clk);
        checkOutput("resumeDataGrant", 32'(grant_d), 32'd1);
        @(negedge clk);
        d_req = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] timeout");
        applyStimulus(1'b1, 32'h4000, 4'b0000, 32'h0, 1, 1'b1, 32'h0, 1'b1);
        @(negedge clk);
        checkOutput("timeoutMReq", 32'(m_req), 32'd0);

        $display("[TB] reset mid-access");
        @(negedge clk);
        memHang = 1'b1;
        d_req = 1'b1; d_addr = 32'h3000; d_we = 4'b0000;
        @(negedge clk);
        checkOutput("preRstMReq", 32'(m_req), 32'd1);
        checkOutput("preRstGrantD", 32'(grant_d), 32'd1);
        @(negedge clk);
        #1 clrn = 1'b1;
        #1;
        checkOutput("asyncRstMReq", 32'(m_req), 32'd0);
        checkOutput("asyncRstGrantD", 32'(grant_d), 32'd0);
        checkOutput("asyncRstDAck", 32'(d_ack), 32'd0);
        d_req = 1'b0;
        @(negedge clk);
        clrn = 1'b0;
        memHang = 1'b0;
        applyStimulus(1'b0, 32'h100, 4'b0000, 32'h0, 2, 1'b0, 32'h00500093, 1'b0);

        repeat (5) @(negedge clk);
        checkOutput("queueEmpty", 32'(expQ.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checkCnt, failCnt);
        $finish;
    end

endmodule

// File: doc/riscv_mem_arbiter.md
# riscv_mem_arbiter

Sequencing arbiter that shares one single-ported, variable-latency memory bus between the RV32I core's instruction-fetch port and its load/store port. It sits between the core and main memory, serialises requests, and returns read data with a one-cycle acknowledge. Data accesses take priority over fetch, with a starvation guard for fetch. A watchdog terminates accesses that memory never completes.

## Interface
- TIMEOUT, 255: cycles in BUSY without `m_ready` before the access is aborted; range 1..65535.
- STARVE_MAX, 4: consecutive data grants allowed while fetch is pending; range 1..255.
- clk  in  1  system clock; all state changes on the rising edge.
- clrn  in  1  reset. Asynchronous, active-high (1 = reset).
- i_req  in  1  fetch request; held with `i_addr` stable until `i_ack`.
- i_addr  in  32  fetch word address.
- i_rdata  out  32  fetch data; valid when `i_ack` is 1.
- i_ack  out  1  one-cycle fetch completion pulse.
- i_err  out  1  qualifies `i_ack`: the access timed out.
- d_req  in  1  data request; held with `d_*` stable until `d_ack`.
- d_addr  in  32  data address.
- d_we  in  4  byte write enables; 0 means read.
- d_wdata  in  32  store data.
- d_rdata  out  32  load data; valid when `d_ack` is 1.
- d_ack  out  1  one-cycle data completion pulse.
- d_err  out  1  qualifies `d_ack`: the access timed out.
- m_req  out  1  memory access valid.
- m_addr  out  32  memory address.
- m_we  out  4  memory byte write enables.
- m_wdata  out  32  memory write data.
- m_rdata  in  32  memory read data; sampled when `m_ready` is 1.
- m_ready  in  1  memory completion; sampled only while `m_req` is 1.
- grant_d  out  1  1 while the current or last access belongs to the data port.

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D. All outputs are registered.
- Reset values: state IDLE; every output 0; timeout counter 0; starvation counter 0.
- IDLE, arbitration. A requester is eligible if its `req` is 1 and its `ack` is 0 in the same cycle; the ack cycle is ignored to prevent a double grant.
  - Only data eligible: grant data.
  - Only fetch eligible: grant fetch.
  - Both eligible: grant fetch if `starve_cnt == STARVE_MAX`, otherwise grant data.
- On a grant:
  - Latch the address, write enables and write data into the `m_*` registers; `m_we` is 0 for fetch.
  - Set `m_req` to 1 and `grant_d` to match the winner.
  - Enter BUSY_I or BUSY_D.
- Starvation counter, updated at each grant:
  - Data grant with `i_req` = 1: increment, saturating at STARVE_MAX.
  - Fetch grant, or data grant with `i_req` = 0: clear to 0.
- BUSY_x: hold all `m_*` stable and increment the timeout counter each cycle.
  - `m_ready` = 1: drop `m_req`. For reads (`m_we` = 0) capture `m_rdata` into the granted port's rdata register; for writes the rdata register keeps its previous value. Pulse that port's `ack` for one cycle with `err` = 0. Clear the counter and return to IDLE.
  - Counter reaches TIMEOUT-1 with `m_ready` = 0: drop `m_req`, pulse `ack` with `err` = 1 and rdata = 0, clear the counter, return to IDLE.
- `m_ready` while `m_req` = 0 is ignored.
- The ungranted port's `ack` and `err` stay 0 throughout.
- Asserting `clrn` mid-access returns everything to reset values immediately: `m_req` drops asynchronously and no `ack` is issued. The requester re-issues after reset.

## Timing
- Request sampled in IDLE at edge N → `m_req` = 1 after edge N.
- `m_ready` sampled at edge N+k (k ≥ 1) → `ack` = 1 after edge N+k for one cycle.
- Minimum access: 2 cycles from `req` to `ack`.
- Back-to-back: the next grant is made at the edge ending the `ack` cycle, so sustained throughput is 1 access per (memory latency + 1) cycles.
- Timeout: `ack` with `err` is asserted TIMEOUT cycles after `m_req` rose.
- `i_rdata`/`d_rdata` hold their values until that port's next read completes.

## Test plan
- Single fetch: `i_req` with `i_addr`=0x100, memory returns 0x00500093 with `m_ready` on the 1st BUSY cycle → `i_ack`=1 exactly 2 cycles after `i_req`, `i_rdata`=0x00500093, `m_we`=0.
- Store then load: `d_req` with `d_we`=4'b0011, `d_addr`=0x2000, `d_wdata`=0x1234; then a read of 0x2000 with memory latency 3 → `m_we`=0011 during the write; on the read, `d_ack` arrives 4 cycles after `d_req` and `d_rdata`=0x1234.
- Simultaneous requests: `i_req` and `d_req` rise together with latency 1 → data served first; `i_ack` follows `d_ack` by 2 cycles; no double `d_ack` in the cycle after `d_ack`.
- Starvation, STARVE_MAX=4: `d_req` re-issued continuously, `i_req` held → exactly 4 data grants, then a fetch grant, then data resumes.
- Timeout, TIMEOUT=8: `m_ready` held 0 on a data read → `d_ack`=1, `d_err`=1, `d_rdata`=0 eight cycles after `m_req` rose; `m_req`=0 afterwards.
- Reset mid-access: assert `clrn` during BUSY_D → `m_req`, `grant_d`, `d_ack` are 0 immediately without waiting for an edge; after release, a new fetch completes normally.
